// File: rtl/cross_domain_pulse_mc.sv
// Multi-channel loss-free pulse crossing from clk_in to clk_out.
// Each channel uses a toggle req/ack handshake. A pending counter queues bursts.
module cross_domain_pulse_mc #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int EDGE_MODE   = 1
) (
    input  logic            clk_in,
    input  logic            ff_in_rst,
    input  logic            clk_out,
    input  logic [N_CH-1:0] pulse_in,
    input  logic [N_CH-1:0] ovf_clr,
    output logic [N_CH-1:0] busy,
    output logic [N_CH-1:0] overflow,
    output logic [N_CH-1:0] pulse_out
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // clk_in domain
    logic [N_CH-1:0]        pin_d;
    logic [N_CH-1:0]        evt;
    logic [N_CH-1:0]        req;
    logic [N_CH-1:0]        ack_sync;
    logic [N_CH-1:0]        idle;
    logic [N_CH-1:0]        launch;
    logic [N_CH-1:0]        pend_nz;
    logic [N_CH-1:0]        drop;
    logic [CNT_W-1:0]       pend  [N_CH];
    logic [SYNC_STAGES-1:0] ack_s [N_CH];

    // clk_out domain
    logic [SYNC_STAGES-1:0] rst_out_s;
    logic                   out_rst_n;
    logic [SYNC_STAGES-1:0] req_s [N_CH];
    logic [N_CH-1:0]        req_seen;

    always_comb begin
        ack_sync = '0;
        pend_nz  = '0;
        drop     = '0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            ack_sync[ch] = ack_s[ch][SYNC_STAGES-1];
            pend_nz[ch]  = (pend[ch] != '0);
        end
        evt    = (EDGE_MODE != 0) ? (pulse_in & ~pin_d) : pulse_in;
        idle   = ~(req ^ ack_sync);
        launch = idle & (pend_nz | evt);
        busy   = ~idle | pend_nz;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            drop[ch] = (pend[ch] == CNT_MAX) & evt[ch] & ~launch[ch];
        end
    end

    always_ff @(posedge clk_in or posedge ff_in_rst) begin
        if (ff_in_rst) begin
            pin_d    <= '0;
            req      <= '0;
            overflow <= '0;
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                pend[ch]  <= '0;
                ack_s[ch] <= '0;
            end
        end else begin
            pin_d    <= pulse_in;
            req      <= req ^ launch;
            // A drop on the same edge as a clear keeps the flag set.
            overflow <= drop | (overflow & ~ovf_clr);
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                ack_s[ch] <= {ack_s[ch][SYNC_STAGES-2:0], req_seen[ch]};
                if (launch[ch] && !evt[ch]) begin
                    pend[ch] <= pend[ch] - CNT_ONE;
                end else if (evt[ch] && !launch[ch] && !drop[ch]) begin
                    pend[ch] <= pend[ch] + CNT_ONE;
                end
            end
        end
    end

    // Destination reset: asserts with ff_in_rst, releases after SYNC_STAGES clk_out edges.
    always_ff @(posedge clk_out or posedge ff_in_rst) begin
        if (ff_in_rst) begin
            rst_out_s <= '0;
        end else begin
            rst_out_s <= {rst_out_s[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign out_rst_n = rst_out_s[SYNC_STAGES-1];

    always_ff @(posedge clk_out or negedge out_rst_n) begin
        if (!out_rst_n) begin
            req_seen  <= '0;
            pulse_out <= '0;
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                req_s[ch] <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                req_s[ch]     <= {req_s[ch][SYNC_STAGES-2:0], req[ch]};
                req_seen[ch]  <= req_s[ch][SYNC_STAGES-1];
                pulse_out[ch] <= req_s[ch][SYNC_STAGES-1] ^ req_seen[ch];
            end
        end
    end

endmodule

// File: tb/tb_cross_domain_pulse_mc.sv
`timescale 1ns/100ps
// Directed bench for cross_domain_pulse_mc: edge mode, level mode, small-counter overflow.
module tb_cross_domain_pulse_mc;
    logic    clk_in    = 1'b0;
    logic    clk_out   = 1'b0;
    logic    ff_in_rst = 1'b0;
    realtime h_out     = 15.0;

    logic [3:0] pin_e = '0, pin_a = '0, pin_b = '0, clr_b = '0;
    logic [3:0] busy_e, busy_a, busy_b, ovf_e, ovf_a, ovf_b, pout_e, pout_a, pout_b;

    cross_domain_pulse_mc #(.N_CH(4), .SYNC_STAGES(2), .CNT_W(4), .EDGE_MODE(1)) dut_e (
        .clk_in(clk_in), .ff_in_rst(ff_in_rst), .clk_out(clk_out), .pulse_in(pin_e),
        .ovf_clr(4'b0), .busy(busy_e), .overflow(ovf_e), .pulse_out(pout_e));
    cross_domain_pulse_mc #(.N_CH(4), .SYNC_STAGES(2), .CNT_W(4), .EDGE_MODE(0)) dut_a (
        .clk_in(clk_in), .ff_in_rst(ff_in_rst), .clk_out(clk_out), .pulse_in(pin_a),
        .ovf_clr(4'b0), .busy(busy_a), .overflow(ovf_a), .pulse_out(pout_a));
    cross_domain_pulse_mc #(.N_CH(4), .SYNC_STAGES(2), .CNT_W(2), .EDGE_MODE(0)) dut_b (
        .clk_in(clk_in), .ff_in_rst(ff_in_rst), .clk_out(clk_out), .pulse_in(pin_b),
        .ovf_clr(clr_b), .busy(busy_b), .overflow(ovf_b), .pulse_out(pout_b));

    always #5 clk_in = ~clk_in;
    initial begin
        #3;
        forever begin
            clk_out = ~clk_out;
            #(h_out);
        end
    end

    int cnt_e[4], cnt_a[4], cnt_b[4], rise_e[4];
    int out_edges = 0, wide = 0, gap_a1 = 0, min_gap_a1 = 1000;
    logic [3:0] prev_e = '0, prev_a = '0, prev_b = '0;

    always @(negedge clk_out) begin
        out_edges++;
        gap_a1++;
        for (int c = 0; c < 4; c++) begin
            if (pout_e[c]) begin
                cnt_e[c]++;
                rise_e[c] = out_edges;
            end
            if (pout_a[c]) cnt_a[c]++;
            if (pout_b[c]) cnt_b[c]++;
        end
        if (pout_a[1]) begin
            if (gap_a1 < min_gap_a1) min_gap_a1 = gap_a1;
            gap_a1 = 0;
        end
        wide += $countones(pout_e & prev_e) + $countones(pout_a & prev_a) + $countones(pout_b & prev_b);
        prev_e = pout_e;
        prev_a = pout_a;
        prev_b = pout_b;
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (({busy_e, busy_a, busy_b} != 12'h0) && n < 2000) begin
            tick(1);
            n++;
        end
        check("idle", 32'({busy_e, busy_a, busy_b}), 32'h0);
        repeat (3) @(negedge clk_out);
        tick(1);
    endtask

    initial begin
        int base[4];
        int exp_e[4], exp_a[4];
        int lat, lo, hi;
        logic [31:0] v;
        logic [3:0]  last_e;
        realtime     hs[4];
        hs[0] = 1.3; hs[1] = 3.7; hs[2] = 7.1; hs[3] = 23.3;

        #1 ff_in_rst = 1'b1;
        #1;
        check("rst_busy", 32'({busy_e, busy_a, busy_b}), 32'h0);
        check("rst_ovf",  32'({ovf_e, ovf_a, ovf_b}), 32'h0);
        check("rst_pout", 32'({pout_e, pout_a, pout_b}), 32'h0);
        tick(5);
        ff_in_rst = 1'b0;
        tick(20);

        // single rising edge on ch0, 100 MHz -> 33 MHz
        for (int c = 0; c < 4; c++) base[c] = cnt_e[c];
        pin_e[0] = 1'b1;
        @(posedge clk_in);
        #1;
        pin_e[0] = 1'b0;
        check("single_busy", 32'(busy_e), 32'h1);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk_out);
            #0.5;
            if (pout_e[0]) begin
                lat = i;
                break;
            end
        end
        check("single_lat", 32'(lat >= 3 && lat <= 4), 32'h1);
        @(posedge clk_out);
        #0.5;
        check("single_width", 32'(pout_e[0]), 32'h0);
        wait_idle();
        check("single_cnt0", 32'(cnt_e[0] - base[0]), 32'd1);
        check("single_other", 32'((cnt_e[1] - base[1]) + (cnt_e[2] - base[2]) + (cnt_e[3] - base[3])), 32'd0);

        // level mode: 5 cycles high -> 5 deliveries
        base[1] = cnt_a[1];
        pin_a[1] = 1'b1;
        tick(5);
        pin_a[1] = 1'b0;
        check("lvl5_busy", 32'(busy_a), 32'h2);
        wait_idle();
        check("lvl5_cnt", 32'(cnt_a[1] - base[1]), 32'd5);
        check("lvl5_ovf", 32'(ovf_a), 32'h0);

        // CNT_W=2: 6 cycles high -> 1 launch + 3 queued, 2 dropped
        base[2] = cnt_b[2];
        pin_b[2] = 1'b1;
        tick(4);
        check("ovf_early", 32'(ovf_b), 32'h0);
        tick(1);
        check("ovf_set", 32'(ovf_b), 32'h4);
        tick(1);
        pin_b[2] = 1'b0;
        wait_idle();
        check("ovf_cnt", 32'(cnt_b[2] - base[2]), 32'd4);
        check("ovf_sticky", 32'(ovf_b), 32'h4);
        clr_b[2] = 1'b1;
        tick(1);
        clr_b[2] = 1'b0;
        check("ovf_clr", 32'(ovf_b), 32'h0);
        base[2] = cnt_b[2];
        pin_b[2] = 1'b1;
        tick(4);
        check("ovf_pre", 32'(ovf_b), 32'h0);
        clr_b[2] = 1'b1;
        tick(1);
        check("ovf_set_wins", 32'(ovf_b), 32'h4);
        clr_b[2] = 1'b0;
        pin_b[2] = 1'b0;
        wait_idle();
        check("ovf_cnt2", 32'(cnt_b[2] - base[2]), 32'd4);

        // all channels on one edge, clk_out 4x faster
        h_out = 1.25;
        tick(5);
        for (int c = 0; c < 4; c++) base[c] = cnt_e[c];
        pin_e = 4'hF;
        tick(1);
        pin_e = 4'h0;
        check("all4_busy", 32'(busy_e), 32'hF);
        wait_idle();
        v = '0;
        for (int c = 0; c < 4; c++) v[c] = (cnt_e[c] - base[c] == 1);
        check("all4_cnt", v, 32'hF);
        lo = rise_e[0];
        hi = rise_e[0];
        for (int c = 1; c < 4; c++) begin
            if (rise_e[c] < lo) lo = rise_e[c];
            if (rise_e[c] > hi) hi = rise_e[c];
        end
        check("all4_skew", 32'(hi - lo <= 1), 32'h1);

        // reset while ch0 has a transfer in flight and pend = 3
        h_out = 15.0;
        tick(5);
        pin_a[0] = 1'b1;
        tick(4);
        pin_a[0] = 1'b0;
        check("mid_busy", 32'(busy_a), 32'h1);
        #2 ff_in_rst = 1'b1;
        #1;
        base[0] = cnt_a[0];
        check("mid_rst_busy", 32'({busy_e, busy_a, busy_b}), 32'h0);
        check("mid_rst_ovf",  32'({ovf_e, ovf_a, ovf_b}), 32'h0);
        check("mid_rst_pout", 32'({pout_e, pout_a, pout_b}), 32'h0);
        tick(2);
        ff_in_rst = 1'b0;
        tick(60);
        check("mid_nopulse", 32'(cnt_a[0] - base[0]), 32'd0);
        check("mid_idle", 32'(busy_a), 32'h0);
        pin_a[0] = 1'b1;
        tick(1);
        pin_a[0] = 1'b0;
        wait_idle();
        check("mid_new", 32'(cnt_a[0] - base[0]), 32'd1);

        // random streams, random clock ratio, bounded so no counter saturates
        for (int c = 0; c < 4; c++) begin
            base[c]  = cnt_e[c];
            exp_e[c] = cnt_a[c];
            exp_a[c] = 0;
        end
        for (int r = 0; r < 4; r++) begin
            h_out = hs[$urandom_range(0, 3)];
            tick(5);
            last_e = '0;
            for (int k = 0; k < 12; k++) begin
                v = $urandom;
                pin_e = v[3:0];
                pin_a = v[7:4];
                for (int c = 0; c < 4; c++) begin
                    if (pin_e[c] && !last_e[c]) exp_e[c] = exp_e[c];
                end
                tick(1);
                for (int c = 0; c < 4; c++) begin
                    if (pin_e[c] && !last_e[c]) exp_a[c] += 32'h10000;
                    if (pin_a[c]) exp_a[c] += 1;
                end
                last_e = pin_e;
            end
            pin_e = '0;
            pin_a = '0;
            wait_idle();
        end
        for (int c = 0; c < 4; c++) begin
            check("rnd_edge_cnt", 32'(cnt_e[c] - base[c]), 32'(exp_a[c] >>> 16));
            check("rnd_lvl_cnt",  32'(cnt_a[c] - exp_e[c]), 32'(exp_a[c] & 32'hFFFF));
        end
        check("rnd_ovf", 32'({ovf_e, ovf_a}), 32'h0);

        check("pulse_width", 32'(wide), 32'd0);
        check("min_gap", 32'(min_gap_a1 >= 3), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cross_domain_pulse_mc.md
# cross_domain_pulse_mc

Multi-channel, loss-free pulse synchroniser from the `clk_in` domain to the `clk_out` domain. It is the parametrised successor of the single-channel pulse crossing. Each channel uses a toggle request/acknowledge handshake and a per-channel pending-event counter, so bursts arriving faster than the handshake round trip are queued and delivered one by one instead of being dropped. It sits between measurement/timer logic clocked by `clk_in` and the bus/control side clocked by `clk_out`.

## Interface
Parameters:
- `N_CH`, 4: number of independent channels.
- `SYNC_STAGES`, 2: synchroniser flops per crossing, legal range 2..4.
- `CNT_W`, 4: pending-counter width; the counter holds at most 2^CNT_W−1 queued events per channel.
- `EDGE_MODE`, 1: 1 = rising edge of `pulse_in` is one event; 0 = every `clk_in` cycle with `pulse_in` high is one event.

Ports:
- `clk_in`, in, 1: source clock.
- `ff_in_rst`, in, 1: reset, asynchronous, active-high, clock `clk_in`.
- `clk_out`, in, 1: destination clock, asynchronous to `clk_in`.
- `pulse_in`, in, N_CH: event inputs, `clk_in` domain.
- `ovf_clr`, in, N_CH: per-channel clear of `overflow`, `clk_in` domain.
- `busy`, out, N_CH: channel has a transfer in flight or pending events, `clk_in` domain.
- `overflow`, out, N_CH: sticky flag, at least one event was dropped, `clk_in` domain.
- `pulse_out`, out, N_CH: one `clk_out`-cycle pulse per delivered event.

## Operation
- Reset: `ff_in_rst` asynchronously clears every flop in both domains.
  - `clk_in` flops release on `ff_in_rst` deassertion. Integration guarantees that deassertion is synchronous to `clk_in`.
  - `clk_out` flops use an internal reset synchroniser: asynchronous assert, deassert after `SYNC_STAGES` `clk_out` edges.
  - Reset values: `pulse_out` = 0, `busy` = 0, `overflow` = 0. Internal `req`, `ack`, counters, edge-detect and sync flops are all 0.
- Event detect, per channel, in the `clk_in` domain:
  - `pin_d` is a register of `pulse_in`.
  - `evt = pulse_in & ~pin_d` when `EDGE_MODE` = 1; `evt = pulse_in` when `EDGE_MODE` = 0.
- Source handshake, per channel:
  - `idle = (req == ack_sync)`, where `ack_sync` is the last stage of the `SYNC_STAGES` `clk_out`→`clk_in` chain.
  - `launch = idle & (pend != 0 | evt)`. On launch, `req` toggles.
  - `pend` next value = `pend + evt − launch`, unsigned.
  - If `pend` = max and `evt` and not `launch`: `pend` holds at max, the event is dropped, `overflow` is set.
  - `overflow` clears on `ovf_clr`. Simultaneous set and clear: set wins.
  - `busy = ~idle | (pend != 0)`.
- Destination, per channel:
  - `req` passes through sync chain `s[0..SYNC_STAGES-1]` on `clk_out`. `req_seen <= s[last]`.
  - `pulse_out <= s[last] ^ req_seen`.
  - `ack = req_seen` is fed back through the `clk_in` sync chain.
- Channels are fully independent; no arbitration between them.
- Only single-bit toggles cross domains; no multi-bit bus crosses.

## Timing
- Launch latency: an event on a `clk_in` edge in an idle channel with `pend` = 0 toggles `req` on that same edge.
- Forward latency: `pulse_out` rises on `clk_out` edge `SYNC_STAGES+1` after the `req` toggle is first captured, +1 edge of metastability uncertainty. It stays high exactly one `clk_out` cycle.
- Return latency: `ack_sync` matches `req` `SYNC_STAGES` to `SYNC_STAGES+1` `clk_in` edges after `req_seen` toggles.
- The next queued event launches on the first `clk_in` edge with `idle` = 1. Back-to-back `pulse_out` per channel are therefore separated by at least one full round trip.
- Delivered `pulse_out` count always equals accepted events, i.e. total events minus drops.
- Reset mid-transfer: in-flight and pending events are discarded. No `pulse_out` asserts until a new event arrives after reset release.
- Any `clk_in` : `clk_out` frequency ratio is legal. Throughput per channel is bounded by the round trip.

## Test plan
- Single pulse, `SYNC_STAGES` = 2, `EDGE_MODE` = 1, `clk_in` 100 MHz / `clk_out` 33 MHz, 1-cycle pulse on ch0 → exactly one `pulse_out[0]`, one `clk_out` cycle wide, within 3–4 `clk_out` edges. `busy[0]` drops afterwards; other channels stay 0.
- `EDGE_MODE` = 0, `pulse_in[1]` high 5 consecutive `clk_in` cycles → exactly 5 `pulse_out[1]`, each separated by ≥1 round trip. `overflow[1]` = 0.
- `CNT_W` = 2, `EDGE_MODE` = 0, `pulse_in[2]` high 6 cycles → 1 immediate launch + 3 queued = 4 `pulse_out[2]`. `overflow[2]` = 1 until `ovf_clr[2]`. Clear and new overflow on the same cycle → stays 1.
- All 4 channels pulsed on the same `clk_in` edge with `clk_out` 4× faster than `clk_in` → one `pulse_out` on each channel, with identical latency ±1 `clk_out` cycle.
- Assert `ff_in_rst` while ch0 has `pend` = 3 and a transfer in flight → all outputs 0 immediately. No `pulse_out[0]` after release until a new event; one new event → exactly one output.
- Randomised event streams on all channels with random clock ratio, no overflow → per-channel `pulse_out` count equals `evt` count.
